seg7_scan_reader: RTL and testbench

//  Receive side of the multiplexed 7-segment display interface: samples segment lines and
//  one-hot digit enables, waits for each dwell to settle, decodes glyphs back to BCD.

---
 rtl/seg7_pkg.sv | 24 ++
 rtl/seg7_glyph_decode.sv | 33 +++
 rtl/seg7_scan_reader.sv | 146 ++++++++++++++
 tb/tb_seg7_scan_reader.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display path: glyph constants, the
// decode error code and the receive-side FSM states.
package seg7_pkg;

  localparam logic [6:0] SEG7_0 = 7'h7E;
  localparam logic [6:0] SEG7_1 = 7'h30;
  localparam logic [6:0] SEG7_2 = 7'h6D;
  localparam logic [6:0] SEG7_3 = 7'h79;
  localparam logic [6:0] SEG7_4 = 7'h33;
  localparam logic [6:0] SEG7_5 = 7'h5B;
  localparam logic [6:0] SEG7_6 = 7'h5F;
  localparam logic [6:0] SEG7_7 = 7'h70;
  localparam logic [6:0] SEG7_8 = 7'h7F;
  localparam logic [6:0] SEG7_9 = 7'h7B;

  localparam logic [3:0] SEG7_ERR_BCD = 4'hF;

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_SETTLE,
    ST_HELD
  } state_t;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational glyph decoder: segment pattern (seg[6]=a .. seg[0]=g) to BCD.
// Unknown patterns, blank included, give SEG7_ERR_BCD with err set.
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       err
);

  // Table lookup against the shared glyph constants.
  always_comb begin
    bcd = SEG7_ERR_BCD;
    err = 1'b0;
    case (seg)
      SEG7_0:  bcd = 4'd0;
      SEG7_1:  bcd = 4'd1;
      SEG7_2:  bcd = 4'd2;
      SEG7_3:  bcd = 4'd3;
      SEG7_4:  bcd = 4'd4;
      SEG7_5:  bcd = 4'd5;
      SEG7_6:  bcd = 4'd6;
      SEG7_7:  bcd = 4'd7;
      SEG7_8:  bcd = 4'd8;
      SEG7_9:  bcd = 4'd9;
      default: begin
        bcd = SEG7_ERR_BCD;
        err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg7_scan_reader.sv
// Receive side of the multiplexed 7-segment interface. Registers the pins,
// waits for each digit dwell to be stable for STABLE_CYCLES samples, decodes
// the glyph once per dwell and assembles complete frames.
// Optional feature macro: SEG_DP_EN adds the decimal point input dp and the
// per-digit dp_digits output; dp then also takes part in change detection.
module seg7_scan_reader #(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   an,
`ifdef SEG_DP_EN
  input  logic                    dp,
  output logic [NUM_DIGITS-1:0]   dp_digits,
`endif
  output logic [4*NUM_DIGITS-1:0] bcd_digits,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    frame_valid,
  output logic                    frame_err
);

  import seg7_pkg::*;

  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

  logic [6:0]            seg_q, seg_p;
  logic [NUM_DIGITS-1:0] an_q, an_p;
`ifdef SEG_DP_EN
  logic                  dp_q, dp_p;
`endif

  state_t                state;
  logic [7:0]            cnt;
  logic [NUM_DIGITS-1:0] seen;

  logic                  change;
  logic                  an_ok;
  logic [3:0]            dec_bcd;
  logic                  dec_err;
  logic [NUM_DIGITS-1:0] seen_nxt;
  logic [NUM_DIGITS-1:0] err_nxt;

  seg7_glyph_decode u_decode (
    .seg (seg_q),
    .bcd (dec_bcd),
    .err (dec_err)
  );

  // Input registers plus a one-cycle-delayed copy for change detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= '0;
      an_q  <= '0;
      seg_p <= '0;
      an_p  <= '0;
`ifdef SEG_DP_EN
      dp_q  <= 1'b0;
      dp_p  <= 1'b0;
`endif
    end else begin
      seg_q <= seg;
      an_q  <= an;
      seg_p <= seg_q;
      an_p  <= an_q;
`ifdef SEG_DP_EN
      dp_q  <= dp;
      dp_p  <= dp_q;
`endif
    end
  end

  // Change detect, digit-enable validity and the post-capture bookkeeping.
  // an_q is one-hot whenever a capture happens, so it doubles as the digit select.
  always_comb begin
`ifdef SEG_DP_EN
    change = ({an_q, seg_q, dp_q} != {an_p, seg_p, dp_p});
`else
    change = ({an_q, seg_q} != {an_p, seg_p});
`endif
    an_ok    = $onehot(an_q);
    seen_nxt = seen | an_q;
    err_nxt  = (digit_err & ~an_q) | (dec_err ? an_q : '0);
  end

  // Dwell FSM with stability counter; captures exactly once per stable dwell.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_WAIT;
      cnt         <= '0;
      seen        <= '0;
      bcd_digits  <= '0;
      digit_err   <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
`ifdef SEG_DP_EN
      dp_digits   <= '0;
`endif
    end else begin
      frame_valid <= 1'b0;
      case (state)
        ST_WAIT: begin
          if (an_ok) begin
            state <= ST_SETTLE;
            cnt   <= 8'd1;
          end
        end
        ST_SETTLE: begin
          if (change) begin
            state <= an_ok ? ST_SETTLE : ST_WAIT;
            cnt   <= 8'd1;
          end else if (cnt == CNT_LAST) begin
            state <= ST_HELD;
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
              if (an_q[i]) begin
                bcd_digits[4*i +: 4] <= dec_bcd;
`ifdef SEG_DP_EN
                dp_digits[i]         <= dp_q;
`endif
              end
            end
            digit_err <= err_nxt;
            if (&seen_nxt) begin
              frame_valid <= 1'b1;
              frame_err   <= |err_nxt;
              seen        <= '0;
            end else begin
              seen        <= seen_nxt;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_HELD: begin
          if (change) begin
            state <= an_ok ? ST_SETTLE : ST_WAIT;
            cnt   <= 8'd1;
          end
        end
        default: state <= ST_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Self-checking bench for seg7_scan_reader (NUM_DIGITS=4, STABLE_CYCLES=8).
// Reference model: a capture happens on the edge where the last STABLE_CYCLES
// registered samples are identical, the sample before them differs, and the
// digit enable is one-hot.
module tb_seg7_scan_reader;

  localparam int unsigned N = 4;
  localparam int unsigned S = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [6:0]     seg;
  logic [N-1:0]   an;
  logic           dp;
  logic [4*N-1:0] bcd_digits;
  logic [N-1:0]   digit_err;
  logic           frame_valid;
  logic           frame_err;
`ifdef SEG_DP_EN
  logic [N-1:0]   dp_digits;
`endif

  always #5 clk = ~clk;

  seg7_scan_reader #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg         (seg),
    .an          (an),
`ifdef SEG_DP_EN
    .dp          (dp),
    .dp_digits   (dp_digits),
`endif
    .bcd_digits  (bcd_digits),
    .digit_err   (digit_err),
    .frame_valid (frame_valid),
    .frame_err   (frame_err)
  );

  typedef struct packed {
    logic [N-1:0] an;
    logic [6:0]   seg;
    logic         dp;
  } smp_t;

  smp_t           hist[$];
  logic [4*N-1:0] m_bcd;
  logic [N-1:0]   m_err, m_seen, m_dp;
  logic           m_fv, m_ferr;
  int             compared   = 0;
  int             mismatched = 0;
  int             fv_pulses  = 0;

  logic [6:0] glyph [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                             7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

  function automatic logic [4:0] ref_decode(input logic [6:0] s);
    for (int k = 0; k < 10; k++)
      if (glyph[k] == s) return {4'(k), 1'b0};
    return {4'hF, 1'b1};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    smp_t cur;
    bit   same;
    int   idx;
    logic [4:0] d;
    cur.an  = an;
    cur.seg = seg;
    cur.dp  = dp;
    m_fv = 1'b0;
    if (rst) begin
      m_bcd = '0; m_err = '0; m_seen = '0; m_dp = '0; m_ferr = 1'b0;
      hist.delete();
      for (int k = 0; k <= S; k++) hist.push_back('0);
      return;
    end
    same = 1'b1;
    for (int k = 1; k < S; k++)
      if (hist[k] != hist[S]) same = 1'b0;
    if (same && hist[0] != hist[1] && $onehot(hist[S].an)) begin
      idx = 0;
      for (int k = 0; k < N; k++) if (hist[S].an[k]) idx = k;
      d = ref_decode(hist[S].seg);
      m_bcd[4*idx +: 4] = d[4:1];
      m_err[idx]  = d[0];
      m_dp[idx]   = hist[S].dp;
      m_seen[idx] = 1'b1;
      if (&m_seen) begin
        m_fv   = 1'b1;
        m_ferr = |m_err;
        m_seen = '0;
      end
    end
    void'(hist.pop_front());
    hist.push_back(cur);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("bcd_digits", 64'(bcd_digits), 64'(m_bcd));
    check("digit_err", 64'(digit_err), 64'(m_err));
    check("frame_valid", 64'(frame_valid), 64'(m_fv));
    check("frame_err", 64'(frame_err), 64'(m_ferr));
`ifdef SEG_DP_EN
    check("dp_digits", 64'(dp_digits), 64'(m_dp));
`endif
    if (frame_valid === 1'b1) fv_pulses++;
  endtask

  task automatic dwell(input logic [N-1:0] a, input logic [6:0] s, input int unsigned len);
    an  = a;
    seg = s;
    repeat (len) tick();
  endtask

  initial begin
    rst = 1'b1; an = '0; seg = '0; dp = 1'b0;
    repeat (3) tick();
    check("reset_bcd", 64'(bcd_digits), 64'h0);
    check("reset_fv", 64'(frame_valid), 64'h0);
    rst = 1'b0;

    // Full frame 0,1,2,3 in digit order.
    fv_pulses = 0;
    dwell(4'b0001, 7'h7E, 12);
    dwell(4'b0010, 7'h30, 12);
    dwell(4'b0100, 7'h6D, 12);
    dwell(4'b1000, 7'h79, 12);
    check("t1_bcd", 64'(bcd_digits), 64'h3210);
    check("t1_pulses", 64'(fv_pulses), 64'd1);
    check("t1_ferr", 64'(frame_err), 64'h0);

    // Short dwell gives no capture.
    dwell(4'b0001, 7'h7F, 5);
    dwell(4'b0000, 7'h00, 4);
    check("t2_nib0", 64'(bcd_digits[3:0]), 64'h0);

    // Blank glyph on digit 2 flags an error frame.
    fv_pulses = 0;
    dwell(4'b0100, 7'h00, 10);
    dwell(4'b0001, 7'h7E, 10);
    dwell(4'b0010, 7'h30, 10);
    dwell(4'b1000, 7'h79, 10);
    check("t3_bcd", 64'(bcd_digits), 64'h3F10);
    check("t3_derr", 64'(digit_err), 64'b0100);
    check("t3_ferr", 64'(frame_err), 64'h1);
    check("t3_pulses", 64'(fv_pulses), 64'd1);

    // Invalid enables hold everything; a glitch restarts the stability count.
    dwell(4'b0011, 7'h7E, 20);
    dwell(4'b0000, 7'h30, 20);
    check("t4_hold_bcd", 64'(bcd_digits), 64'h3F10);
    dwell(4'b0010, 7'h5B, 5);
    dwell(4'b0010, 7'h7F, 1);
    dwell(4'b0010, 7'h5B, 8);
    check("t4_glitch_pre", 64'(bcd_digits[7:4]), 64'h1);
    dwell(4'b0010, 7'h5B, 1);
    check("t4_glitch_cap", 64'(bcd_digits[7:4]), 64'h5);

    // Reset discards a partial frame.
    dwell(4'b0001, 7'h7E, 10);
    dwell(4'b0010, 7'h30, 10);
    dwell(4'b0100, 7'h6D, 10);
    rst = 1'b1;
    tick();
    check("t5_rst_bcd", 64'(bcd_digits), 64'h0);
    check("t5_rst_derr", 64'(digit_err), 64'h0);
    check("t5_rst_ferr", 64'(frame_err), 64'h0);
    rst = 1'b0;
    fv_pulses = 0;
    dwell(4'b1000, 7'h79, 12);
    check("t5_pulses", 64'(fv_pulses), 64'd0);
    check("t5_bcd", 64'(bcd_digits), 64'h3000);

`ifdef SEG_DP_EN
    // Decimal point capture and dp-only change detection.
    dp = 1'b1;
    dwell(4'b0010, 7'h5B, 10);
    check("t6_nib1", 64'(bcd_digits[7:4]), 64'h5);
    check("t6_dp", 64'(dp_digits), 64'b0010);
    dp = 1'b0;
    dwell(4'b0100, 7'h33, 4);
    dp = 1'b1;
    dwell(4'b0100, 7'h33, 8);
    check("t6_dp_restart", 64'(bcd_digits[11:8]), 64'h0);
    dwell(4'b0100, 7'h33, 1);
    check("t6_dp_cap", 64'(bcd_digits[11:8]), 64'h4);
    check("t6_dp2", 64'(dp_digits[2]), 64'h1);
    dp = 1'b0;
`endif

    // Randomized dwells against the reference model.
    for (int t = 0; t < 300; t++) begin
      logic [N-1:0] a;
      logic [6:0]   s;
      int unsigned  r;
      r = $urandom_range(0, 9);
      if (r == 0)      a = '0;
      else if (r == 1) a = N'($urandom);
      else             a = N'(1) << $urandom_range(0, N - 1);
      if ($urandom_range(0, 3) == 0) s = 7'($urandom);
      else                           s = glyph[$urandom_range(0, 9)];
`ifdef SEG_DP_EN
      dp = 1'($urandom);
`endif
      dwell(a, s, $urandom_range(1, 14));
      if ($urandom_range(0, 40) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
